// File: rtl/loop_nest_counter.sv
// Nested-loop index generator: odometer over DIMS levels, one iteration per II enabled cycles.
// valid/last are combinational from state and en; done is registered one cycle after last; en=0 stalls.
module loop_nest_counter #(
  parameter int                DIMS   = 2,
  parameter int                W      = 8,
  parameter logic [DIMS*W-1:0] BOUNDS = {8'd4, 8'd4},
  parameter int                II     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              en,
  output logic [DIMS*W-1:0] idx,
  output logic              valid,
  output logic              last,
  output logic              done,
  output logic              busy
);

  localparam int            PW     = (II > 1) ? $clog2(II) : 1;
  localparam logic [PW-1:0] PH_MAX = PW'(II - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic [PW-1:0]     phase;
  logic [DIMS*W-1:0] idx_inc;
  logic              all_max;
  logic              carry;
  logic [W-1:0]      fld, lim;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state == RUN);
    valid = busy & en & (phase == '0);
    last  = valid & all_max;
  end

  // Odometer: the carry out of the top dim is set exactly when every field sits at its limit.
  always_comb begin
    carry   = 1'b1;
    fld     = '0;
    lim     = '0;
    idx_inc = '0;
    for (int d = 0; d < DIMS; d++) begin
      fld = idx[d*W +: W];
      lim = BOUNDS[d*W +: W] - W'(1);
      if (carry) idx_inc[d*W +: W] = (fld == lim) ? '0 : fld + W'(1);
      else       idx_inc[d*W +: W] = fld;
      carry = carry & (fld == lim);
    end
    all_max = carry;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx   <= '0;
      phase <= '0;
      done  <= 1'b0;
    end else begin
      done <= last;
      if (state == IDLE) begin
        idx   <= '0;
        phase <= '0;
      end else if (en) begin
        if (last) begin
          idx   <= '0;
          phase <= '0;
        end else begin
          if (valid) idx <= idx_inc;
          phase <= (phase == PH_MAX) ? '0 : phase + PW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_loop_nest_counter.sv
// Bench for loop_nest_counter: table-driven vectors on a 3x2 nest plus scoreboarded
// runs on a 2x2 II=3 nest and a 3-dim {1,4,1} nest.
module tb_loop_nest_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_a = 1'b0, en_a = 1'b0;
  logic        start_b = 1'b0, en_b = 1'b0;
  logic        start_c = 1'b0, en_c = 1'b0;
  logic [15:0] idx_a, idx_b;
  logic [23:0] idx_c;
  logic        valid_a, last_a, done_a, busy_a;
  logic        valid_b, last_b, done_b, busy_b;
  logic        valid_c, last_c, done_c, busy_c;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        st, en, v;
    logic [15:0] idx;
    logic        l, d, b;
  } vec_t;

  typedef struct packed {
    logic [31:0] idx;
    logic        last;
  } exp_t;

  vec_t tab[$];
  exp_t q_b[$];
  exp_t q_c[$];

  always #5 clk = ~clk;

  loop_nest_counter #(.DIMS(2), .W(8), .BOUNDS({8'd3, 8'd2}), .II(1)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .en(en_a), .idx(idx_a),
    .valid(valid_a), .last(last_a), .done(done_a), .busy(busy_a));

  loop_nest_counter #(.DIMS(2), .W(8), .BOUNDS({8'd2, 8'd2}), .II(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .en(en_b), .idx(idx_b),
    .valid(valid_b), .last(last_b), .done(done_b), .busy(busy_b));

  loop_nest_counter #(.DIMS(3), .W(8), .BOUNDS({8'd1, 8'd4, 8'd1}), .II(1)) u_c (
    .clk(clk), .rst(rst), .start(start_c), .en(en_c), .idx(idx_c),
    .valid(valid_c), .last(last_c), .done(done_c), .busy(busy_c));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic st, en, v, input logic [15:0] ix, input logic l, d, b);
    vec_t r;
    r.st = st; r.en = en; r.v = v; r.idx = ix; r.l = l; r.d = d; r.b = b;
    tab.push_back(r);
  endtask

  // Mixed-radix decomposition of iteration number n, dim 0 least significant.
  function automatic logic [31:0] mk_idx(int n, int b0, int b1, int b2);
    int r;
    logic [31:0] v;
    r = n;
    v = '0;
    v[7:0]   = 8'(r % b0); r = r / b0;
    v[15:8]  = 8'(r % b1); r = r / b1;
    v[23:16] = 8'(r % b2);
    return v;
  endfunction

  always @(negedge clk) begin
    if (valid_b === 1'b1) begin
      if (q_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_extra_iter: got idx %0h want no iteration", idx_b);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        chk("b_idx", 32'(idx_b), e.idx);
        chk("b_last", 32'(last_b), 32'(e.last));
      end
    end
    if (valid_c === 1'b1) begin
      if (q_c.size() == 0) begin
        checks++; errors++;
        $display("FAIL c_extra_iter: got idx %0h want no iteration", idx_c);
      end else begin
        exp_t e;
        e = q_c.pop_front();
        chk("c_idx", 32'(idx_c), e.idx);
        chk("c_last", 32'(last_c), 32'(e.last));
      end
    end
  end

  initial begin
    // 3x2 nest, II=1: plain run with a mid-run start that must be ignored.
    add(1,1,0,16'h0000,0,0,0);
    add(0,1,1,16'h0000,0,0,1);
    add(0,1,1,16'h0001,0,0,1);
    add(1,1,1,16'h0100,0,0,1);
    add(0,1,1,16'h0101,0,0,1);
    add(0,1,1,16'h0200,0,0,1);
    add(0,1,1,16'h0201,1,0,1);
    add(0,1,0,16'h0000,0,1,0);
    add(0,1,0,16'h0000,0,0,0);
    // Start accepted with en low; two-cycle stall after the third iteration.
    add(1,0,0,16'h0000,0,0,0);
    add(0,1,1,16'h0000,0,0,1);
    add(0,1,1,16'h0001,0,0,1);
    add(0,1,1,16'h0100,0,0,1);
    add(0,0,0,16'h0101,0,0,1);
    add(0,0,0,16'h0101,0,0,1);
    add(0,1,1,16'h0101,0,0,1);
    add(0,1,1,16'h0200,0,0,1);
    add(0,1,1,16'h0201,1,0,1);
    add(0,1,0,16'h0000,0,1,0);
    // Back-to-back runs: start in the done cycle.
    add(1,1,0,16'h0000,0,0,0);
    add(0,1,1,16'h0000,0,0,1);
    add(0,1,1,16'h0001,0,0,1);
    add(0,1,1,16'h0100,0,0,1);
    add(0,1,1,16'h0101,0,0,1);
    add(0,1,1,16'h0200,0,0,1);
    add(0,1,1,16'h0201,1,0,1);
    add(1,1,0,16'h0000,0,1,0);
    add(0,1,1,16'h0000,0,0,1);
    add(0,1,1,16'h0001,0,0,1);
    add(0,1,1,16'h0100,0,0,1);
    add(0,1,1,16'h0101,0,0,1);
    add(0,1,1,16'h0200,0,0,1);
    add(0,1,1,16'h0201,1,0,1);
    add(0,1,0,16'h0000,0,1,0);
    add(0,1,0,16'h0000,0,0,0);

    #2 rst = 1'b0;
    #1;
    chk("rst_idx", 32'(idx_a), 32'h0);
    chk("rst_valid", 32'(valid_a), 32'h0);
    chk("rst_done", 32'(done_a), 32'h0);
    chk("rst_busy", 32'({busy_a, busy_b, busy_c}), 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    foreach (tab[i]) begin
      @(posedge clk);
      #1;
      start_a = tab[i].st;
      en_a    = tab[i].en;
      @(negedge clk);
      chk($sformatf("a_valid[%0d]", i), 32'(valid_a), 32'(tab[i].v));
      chk($sformatf("a_idx[%0d]", i),   32'(idx_a),   32'(tab[i].idx));
      chk($sformatf("a_last[%0d]", i),  32'(last_a),  32'(tab[i].l));
      chk($sformatf("a_done[%0d]", i),  32'(done_a),  32'(tab[i].d));
      chk($sformatf("a_busy[%0d]", i),  32'(busy_a),  32'(tab[i].b));
    end

    // Asynchronous reset in the middle of a run, between clock edges.
    @(posedge clk); #1 start_a = 1'b1; en_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("pre_rst_valid", 32'(valid_a), 32'h1);
    chk("pre_rst_idx", 32'(idx_a), 32'h0100);
    rst = 1'b0;
    #1;
    chk("arst_idx", 32'(idx_a), 32'h0);
    chk("arst_valid", 32'(valid_a), 32'h0);
    chk("arst_last", 32'(last_a), 32'h0);
    chk("arst_done", 32'(done_a), 32'h0);
    chk("arst_busy", 32'(busy_a), 32'h0);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    chk("post_rst_busy0", 32'(busy_a), 32'h0);
    @(negedge clk);
    chk("post_rst_busy1", 32'({busy_a, valid_a}), 32'h0);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    chk("restart_valid", 32'(valid_a), 32'h1);
    chk("restart_idx", 32'(idx_a), 32'h0);
    @(posedge clk); #1 en_a = 1'b0;

    // 2x2 nest, II=3: valid at cycles 1,4,7,10 after the start edge, done at 11.
    @(posedge clk); #1 en_b = 1'b1; start_b = 1'b1;
    for (int n = 0; n < 4; n++) q_b.push_back('{mk_idx(n, 2, 2, 1), n == 3});
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(posedge clk); #1 start_b = 1'b0;
      @(negedge clk);
      chk($sformatf("b_valid@%0d", cyc), 32'(valid_b),
          32'(cyc >= 1 && cyc <= 10 && (cyc - 1) % 3 == 0));
      chk($sformatf("b_done@%0d", cyc), 32'(done_b), 32'(cyc == 11));
      chk($sformatf("b_busy@%0d", cyc), 32'(busy_b), 32'(cyc >= 1 && cyc <= 10));
    end

    // 3-dim nest {1,4,1}: only dim1 steps.
    @(posedge clk); #1 en_c = 1'b1; start_c = 1'b1;
    for (int n = 0; n < 4; n++) q_c.push_back('{mk_idx(n, 1, 4, 1), n == 3});
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(posedge clk); #1 start_c = 1'b0;
      @(negedge clk);
      chk($sformatf("c_valid@%0d", cyc), 32'(valid_c), 32'(cyc <= 4));
      chk($sformatf("c_done@%0d", cyc), 32'(done_c), 32'(cyc == 5));
    end

    chk("b_queue_drained", 32'(q_b.size()), 32'h0);
    chk("c_queue_drained", 32'(q_c.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/loop_nest_counter.md
LOOP_NEST_COUNTER -- requirements
Module: loop_nest_counter

Interface
REQ-001 SHALL have parameter DIMS, default 2: number of nested loop levels, legal range 1..4; dim 0 is the innermost level.
REQ-002 SHALL have parameter W, default 8: width of each per-dimension index field.
REQ-003 SHALL have parameter BOUNDS, default {8'd4, 8'd4}, width DIMS*W: field d, bits [d*W +: W], is the trip count of dim d; each field SHALL be >= 1.
REQ-004 SHALL have parameter II, default 1: initiation interval in enabled cycles, legal values >= 1.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  one-cycle request to begin a loop nest.
REQ-008 en  in  1  advance enable; low = stall.
REQ-009 idx  out  DIMS*W  current iteration index; field d = index of dim d.
REQ-010 valid  out  1  idx is an issued iteration this cycle.
REQ-011 last  out  1  the issued iteration is the final one.
REQ-012 done  out  1  one-cycle pulse after the final iteration.
REQ-013 busy  out  1  high while the nest is running.

Function
REQ-014 SHALL implement two states, IDLE and RUN; busy = (state == RUN).
REQ-015 In IDLE, start=1 SHALL move the block to RUN at the next edge with idx=0 and the II phase counter at 0; en is ignored for acceptance.
REQ-016 In RUN, start SHALL be ignored.
REQ-017 In RUN, valid SHALL be combinational: en & (II phase == 0); valid SHALL be 0 in IDLE.
REQ-018 The II phase counter SHALL advance only on cycles with en=1, counting 0..II-1 and wrapping; with en=0 it SHALL hold.
REQ-019 On each valid cycle, idx SHALL advance odometer-style: dim 0 increments, and any dim at BOUNDS[d]-1 wraps to 0 and carries into dim d+1.
REQ-020 Each idx field SHALL be unsigned, never exceed BOUNDS[d]-1, and remain 0 for any dim with BOUNDS[d]=1.
REQ-021 last SHALL be valid & (every idx field == BOUNDS[d]-1).
REQ-022 On a last cycle the block SHALL return to IDLE and clear idx to 0; done SHALL be registered and go high for exactly the following cycle.
REQ-023 Iteration count per run SHALL equal the product of all BOUNDS fields, issued in lexicographic order with dim DIMS-1 most significant.
REQ-024 With en held high, if start is sampled at edge 0, valid cycles SHALL be 1, 1+II, ..., 1+II*(P-1) with P the iteration count; done SHALL be high in cycle 2+II*(P-1).
REQ-025 start in the same cycle as done SHALL be accepted; back-to-back runs are therefore legal.
REQ-026 A stall (en=0) SHALL hold idx, the II phase and the state, and SHALL neither drop nor duplicate any iteration.

Reset
REQ-027 rst=0 SHALL force IDLE, idx=0, II phase=0, valid=0, last=0, done=0 and busy=0 immediately, without waiting for clk, including mid-run.
REQ-028 After rst returns high, the block SHALL stay in IDLE until start is sampled.

Verification
REQ-029 DIMS=2, BOUNDS dim1=3 and dim0=2, II=1, en=1, start pulse -> 6 consecutive valid cycles with (d1,d0) = (0,0),(0,1),(1,0),(1,1),(2,0),(2,1); last on the 6th only; done on the next cycle; busy low afterwards.
REQ-030 DIMS=2, BOUNDS 2x2, II=3, en=1 -> valid in cycles 1,4,7,10 after the start edge; done in cycle 11.
REQ-031 Same as REQ-029 with en=0 for 2 cycles after the 3rd iteration -> valid low and idx held at (1,1) during the stall; the sequence then resumes with no gap or repeat and done arrives 2 cycles later than in REQ-029.
REQ-032 start pulsed mid-run -> sequence unaffected; start pulsed during the done cycle -> a new run starts at idx 0 in the next cycle.
REQ-033 rst=0 asserted between edges mid-run -> all outputs 0 before the next edge; after release plus a start, the run restarts at idx 0.
REQ-034 DIMS=3, BOUNDS {1,4,1} (dim2, dim1, dim0) -> 4 iterations with only dim1 stepping 0..3; dim0 and dim2 stay 0 throughout.
